// File: rtl/paralelo_serial_param_if.sv
// Parallel-to-serial lane bus.
// Groups the word handshake (valid_in / in_parallel / ready_out) with the
// serial-side outputs and the status signals of paralelo_serial_param.
//   master : parallel datapath side (drives valid_in, in_parallel)
//   slave  : the converter (drives ready_out, serial outputs and status)
interface paralelo_serial_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             valid_in;
    logic [WIDTH-1:0] in_parallel;
    logic             ready_out;
    logic             out_serial;
    logic             word_start;
    logic             data_valid_out;
    logic [CW-1:0]    fifo_count;
    logic             overflow;

    modport master (
        output valid_in, in_parallel,
        input  ready_out, out_serial, word_start, data_valid_out,
               fifo_count, overflow
    );

    modport slave (
        input  valid_in, in_parallel,
        output ready_out, out_serial, word_start, data_valid_out,
               fifo_count, overflow
    );
endinterface

// File: rtl/paralelo_serial_param.sv
// Parameterised parallel-to-serial converter.
// Buffers WIDTH-bit words in a DEPTH-entry FIFO and shifts one word out every
// WIDTH bit clocks. When nothing is buffered at a word boundary, IDLE_WORD is
// sent instead, with data_valid_out low.
// Ports:
//   clk_32f : serial bit clock, all state on its rising edge
//   reset   : synchronous, active high
//   bus     : slave side of paralelo_serial_param_if
//             valid_in/in_parallel/ready_out  word handshake
//             out_serial, word_start, data_valid_out  serial lane (aligned)
//             fifo_count, overflow (sticky)  status
module paralelo_serial_param #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(8'hBC),
    parameter bit               MSB_FIRST = 1'b1
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    paralelo_serial_param_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int CNTW = $clog2(WIDTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_nxt;
    logic [WIDTH-1:0] shreg, shifted;
    logic [CNTW-1:0]  cnt;
    logic             dv_q, ws_q, ovf_q;
    logic             boundary, push, pop;

    // ready depends only on registered fill level and reset, never on valid_in
    assign bus.ready_out = !reset && (count < CW'(DEPTH));

    always_comb begin
        boundary  = (cnt == CNTW'(WIDTH - 1));
        push      = bus.valid_in && bus.ready_out;
        // pop decision uses the fill level before this edge, so a word
        // written on a boundary edge cannot bypass straight into the shifter
        pop       = boundary && (count != '0);
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
        // shift toward whichever end feeds out_serial
        if (MSB_FIRST) shifted = {shreg[WIDTH-2:0], 1'b0};
        else           shifted = {1'b0, shreg[WIDTH-1:1]};
    end

    // storage has no reset; pointers and count define what is valid
    always_ff @(posedge clk_32f) begin
        if (push) mem[wr_ptr] <= bus.in_parallel;
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            shreg  <= IDLE_WORD;
            cnt    <= '0;
            dv_q   <= 1'b0;
            ws_q   <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            if (bus.valid_in && !bus.ready_out) ovf_q <= 1'b1;
            // next bit is the first of a word exactly when this edge is a boundary
            ws_q <= boundary;
            if (boundary) begin
                cnt <= '0;
                if (pop) begin
                    shreg <= mem[rd_ptr];
                    dv_q  <= 1'b1;
                end else begin
                    shreg <= IDLE_WORD;
                    dv_q  <= 1'b0;
                end
            end else begin
                cnt   <= cnt + CNTW'(1);
                shreg <= shifted;
            end
        end
    end

    // out_serial is taken straight from a shift register flop
    assign bus.out_serial     = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign bus.word_start     = ws_q;
    assign bus.data_valid_out = dv_q;
    assign bus.fifo_count     = count;
    assign bus.overflow       = ovf_q;
endmodule

// File: tb/tb_paralelo_serial_param.sv
module tb_paralelo_serial_param;
    localparam logic [7:0] IDLE_A = 8'hBC;
    localparam logic [9:0] IDLE_B = 10'h17C;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    paralelo_serial_param_if #(.WIDTH(8),  .DEPTH(4)) bus_a ();
    paralelo_serial_param_if #(.WIDTH(10), .DEPTH(4)) bus_b ();

    paralelo_serial_param #(.WIDTH(8), .DEPTH(4), .IDLE_WORD(IDLE_A), .MSB_FIRST(1'b1))
        dut_a (.clk_32f(clk), .reset(rst_a), .bus(bus_a));
    paralelo_serial_param #(.WIDTH(10), .DEPTH(4), .IDLE_WORD(IDLE_B), .MSB_FIRST(1'b0))
        dut_b (.clk_32f(clk), .reset(rst_b), .bus(bus_b));

    int n_cmp = 0;
    int n_bad = 0;

    // reference model for dut_a
    int         m_cnt;
    logic [7:0] m_word;
    bit         m_dv, m_ovf;
    logic [7:0] m_q[$];
    // output-side scoreboard: accepted words, popped as the DUT emits them
    logic [7:0] exp_words[$];
    logic [7:0] col;
    int         col_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step_a();
        bit rdy_pre;
        @(posedge clk);
        rdy_pre = !rst_a && (m_q.size() < 4);
        if (rst_a) begin
            m_q.delete(); exp_words.delete();
            m_cnt = 0; m_word = IDLE_A; m_dv = 0; m_ovf = 0; col_n = 0;
        end else begin
            if (m_cnt == 7) begin
                m_cnt = 0;
                if (m_q.size() > 0) begin m_word = m_q.pop_front(); m_dv = 1; end
                else begin m_word = IDLE_A; m_dv = 0; end
            end else begin
                m_cnt++;
            end
            if (bus_a.valid_in && rdy_pre) begin
                m_q.push_back(bus_a.in_parallel);
                exp_words.push_back(bus_a.in_parallel);
            end else if (bus_a.valid_in) begin
                m_ovf = 1;
            end
        end
        #1;
        chk("out_serial", bus_a.out_serial,     m_word[7-m_cnt]);
        chk("word_start", bus_a.word_start,     m_cnt == 0);
        chk("data_valid", bus_a.data_valid_out, m_dv);
        chk("fifo_count", bus_a.fifo_count,     m_q.size());
        chk("ready_out",  bus_a.ready_out,      !rst_a && (m_q.size() < 4));
        chk("overflow",   bus_a.overflow,       m_ovf);
        if (!rst_a && bus_a.data_valid_out) begin
            if (bus_a.word_start) col_n = 0;
            col = {col[6:0], bus_a.out_serial};
            col_n++;
            if (col_n == 8) begin
                col_n = 0;
                chk("sb_has_word", exp_words.size() > 0, 1);
                if (exp_words.size() > 0) chk("sb_word", col, exp_words.pop_front());
            end
        end
    endtask

    // advance until the model counter (value before the next edge) hits target
    task automatic sync_to(input int target);
        for (int i = 0; i < 20; i++) begin
            if (m_cnt == target) break;
            step_a();
        end
        chk("sync_cnt", m_cnt, target);
    endtask

    task automatic push_a(input logic [7:0] w);
        bus_a.valid_in = 1'b1; bus_a.in_parallel = w;
        step_a();
        bus_a.valid_in = 1'b0;
    endtask

    task automatic step_b();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  w3 [5];
        logic [9:0]  exp_b;
        logic [9:0]  got_b;
        logic [7:0]  got_a;
        w3[0] = 8'hAB; w3[1] = 8'hCA; w3[2] = 8'h12; w3[3] = 8'hDC; w3[4] = 8'hFA;

        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.valid_in = 1'b0; bus_a.in_parallel = '0;
        bus_b.valid_in = 1'b0; bus_b.in_parallel = '0;

        // 1: reset 3 cycles, then idle stream
        repeat (3) step_a();
        chk("rst_word_start", bus_a.word_start, 1);
        chk("rst_ready",      bus_a.ready_out,  0);
        rst_a = 1'b0;
        got_a = '0;
        for (int i = 0; i < 8; i++) begin
            step_a();
            got_a = {got_a[6:0], bus_a.out_serial};
        end
        // first bit came out during reset; the next 8 are bits 6..0 then bit 7
        chk("idle_pattern", got_a, {IDLE_A[6:0], IDLE_A[7]});
        repeat (8) step_a();

        // 2: push 0xAB on the first edge after reset
        rst_a = 1'b1; step_a(); rst_a = 1'b0;
        push_a(8'hAB);
        repeat (24) step_a();

        // 3: burst of 5 into a depth-4 FIFO starting just after a boundary
        sync_to(7); step_a();
        for (int i = 0; i < 5; i++) push_a(w3[i]);
        chk("burst_overflow", bus_a.overflow,   1);
        chk("burst_full",     bus_a.fifo_count, 4);
        repeat (40) step_a();

        // 4: push exactly on a boundary edge with empty FIFO
        sync_to(7);
        chk("t4_empty", m_q.size(), 0);
        push_a(8'h33);
        chk("t4_idle_next", bus_a.data_valid_out, 0);
        repeat (16) step_a();

        // 6: reset at cnt=4 with two words queued
        sync_to(7); step_a();
        push_a(8'h5A); push_a(8'hA5);
        step_a(); step_a();
        chk("t6_cnt4", m_cnt, 4);
        rst_a = 1'b1; step_a();
        chk("t6_count", bus_a.fifo_count, 0);
        chk("t6_ovf",   bus_a.overflow,   0);
        got_a = {7'd0, bus_a.out_serial};
        rst_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step_a();
            got_a = {got_a[6:0], bus_a.out_serial};
        end
        chk("t6_idle", got_a, IDLE_A);
        repeat (16) step_a();
        chk("t6_sb_empty", exp_words.size(), 0);

        // 5: WIDTH=10, LSB first
        rst_b = 1'b1; step_b();
        chk("b_rst_bit",  bus_b.out_serial, IDLE_B[0]);
        chk("b_rst_ws",   bus_b.word_start, 1);
        chk("b_rst_rdy",  bus_b.ready_out,  0);
        rst_b = 1'b0;
        bus_b.valid_in = 1'b1; bus_b.in_parallel = 10'h2A5;
        step_b();
        bus_b.valid_in = 1'b0;
        chk("b_count", bus_b.fifo_count, 1);
        for (int i = 0; i < 8; i++) begin
            step_b();
            chk("b_wait_dv", bus_b.data_valid_out, 0);
        end
        exp_b = 10'h2A5;
        for (int i = 0; i < 10; i++) begin
            step_b();
            chk("b_bit", bus_b.out_serial,     exp_b[i]);
            chk("b_ws",  bus_b.word_start,     i == 0);
            chk("b_dv",  bus_b.data_valid_out, 1);
        end
        got_b = '0;
        for (int i = 0; i < 10; i++) begin
            step_b();
            got_b[i] = bus_b.out_serial;
            chk("b_idle_ws", bus_b.word_start,     i == 0);
            chk("b_idle_dv", bus_b.data_valid_out, 0);
        end
        chk("b_idle_word", got_b, IDLE_B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/paralelo_serial_param.md
Name: paralelo_serial_param

Overview:
- Parametrised successor to the fixed 8-bit parallel-to-serial converter.
- Runs on the serial bit clock only. Buffers parallel words in a DEPTH-entry FIFO with a valid/ready handshake, then serialises one word every WIDTH clocks.
- Emits a programmable idle symbol whenever no data is buffered, and adds a word-boundary strobe, a data-valid marker, a fill level and a sticky overflow flag.
- Sits between the parallel datapath and the serial lane driver.

Parameters:
- WIDTH, 8, bits per word (>=2).
- DEPTH, 4, FIFO entries (power of 2, >=2).
- IDLE_WORD, 8'hBC, word transmitted when the FIFO is empty at a word boundary (WIDTH bits).
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = bit 0 first.

Ports:
- clk_32f  input  1  serial bit clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- valid_in  input  1  in_parallel holds a word to accept.
- in_parallel  input  WIDTH  parallel word.
- ready_out  output  1  FIFO can accept a word this cycle.
- out_serial  output  1  serial bit; registered.
- word_start  output  1  high during the first bit of every transmitted word.
- data_valid_out  output  1  high for all WIDTH bits of a word that came from the FIFO; low for idle words.
- fifo_count  output  $clog2(DEPTH)+1  entries currently buffered.
- overflow  output  1  sticky: a word was offered while ready_out was low.

Behaviour:
- Reset (sampled at the edge while reset=1):
  - FIFO emptied; fifo_count=0; overflow=0.
  - Shift register loaded with IDLE_WORD; bit counter cnt=0.
  - data_valid_out=0; word_start=1; ready_out=0 while reset is high.
  - out_serial = first-transmitted bit of IDLE_WORD.
- ready_out = !reset && (fifo_count < DEPTH). Purely a function of registered state; no combinational path from valid_in.
- Accept: at an edge with valid_in && ready_out, in_parallel is written to the FIFO tail.
- Refused offer: an edge with valid_in && !ready_out (reset low) sets overflow. The word is dropped. Only reset clears overflow.
- Bit counter:
  - If cnt < WIDTH-1: cnt increments and the shift register shifts one position toward the output end.
  - If cnt == WIDTH-1 (word boundary): cnt returns to 0 and the next word is loaded.
- Loading at a word boundary:
  - If the FIFO was non-empty before this edge: pop the head, load it, set data_valid_out=1.
  - Otherwise: load IDLE_WORD and set data_valid_out=0.
- No write-to-pop bypass. A word accepted at the same edge as a boundary with an empty FIFO waits a full word period.
- Simultaneous accept and pop: fifo_count is unchanged. When full, ready_out=0, so no write occurs even if a pop happens on that edge.
- word_start = (cnt==0), registered alongside out_serial. out_serial, word_start and data_valid_out are mutually aligned.
- Latency: a word written into an empty FIFO at an edge with cnt=k (k<WIDTH-1) starts on out_serial WIDTH-1-k cycles later.
- Throughput: one word per WIDTH cycles. Back-to-back words have no gap.
- FIFO pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- Reset mid-word: the current word is aborted and FIFO contents discarded. Output restarts with a full IDLE_WORD on the next cycle.

Test Plan:
1. Reset held 3 cycles, no valid_in -> out_serial repeats 1,0,1,1,1,1,0,0 (0xBC, MSB first); word_start every 8th cycle; data_valid_out=0; ready_out=1 after reset; fifo_count=0.
2. Push 0xAB on the first edge after reset -> 8 idle bits, then 1,0,1,0,1,0,1,1 with data_valid_out=1; then idle resumes.
3. Push 0xAB,0xCA,0x12,0xDC,0xFA on 5 consecutive edges (DEPTH=4) -> ready_out falls after 4 accepted words (or 5 if a pop occurs in between); refused 0xFA sets overflow=1. Serial stream is AB CA 12 DC back-to-back with no idle gap.
4. Push 0x33 exactly at a cnt==7 edge with an empty FIFO -> next word is idle (data_valid_out=0); 0x33 is transmitted in the following word.
5. MSB_FIRST=0, WIDTH=10, IDLE_WORD=10'h17C, push 10'h2A5 -> bits sent LSB first: 1,0,1,0,0,1,0,1,0,1; word_start period 10.
6. Assert reset at cnt=4 with 2 words queued -> fifo_count=0, overflow=0; next 8 bits are 0xBC; queued words never appear.
